// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : exe_muldiv
//  Purpose  : Iterative radix-2 multiply/divide unit for the execute stage.
//             Implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN
//             bits, one step per clock, one operation in flight.
//  Revision : 1.0  initial release
// ============================================================================
module exe_muldiv #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [RD_W-1:0] rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int               CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_op;      // funct3[1:0]; MUL vs DIV is carried by the state
  logic                r_neg;     // negate the final result
  logic [CNT_W-1:0]    r_cnt;     // iterations still to run
  logic [2*XLEN-1:0]   r_prod;    // {partial product, remaining multiplier bits}
  logic [XLEN-1:0]     r_mcand;   // multiplicand magnitude
  logic [XLEN-1:0]     r_rem;     // partial remainder
  logic [XLEN-1:0]     r_quo;     // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0]     r_dvsr;    // divisor magnitude

  // Operand decode at issue time
  logic            w_s1_signed, w_s2_signed, w_s1, w_s2, w_neg;
  logic            w_div0, w_ovf, w_accept, w_last;
  logic [XLEN-1:0] w_mag1, w_mag2;

  assign w_s1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_s2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_s1        = w_s1_signed && rs1[XLEN-1];
  assign w_s2        = w_s2_signed && rs2[XLEN-1];
  assign w_mag1      = w_s1 ? -rs1 : rs1;
  assign w_mag2      = w_s2 ? -rs2 : rs2;
  // Remainder follows the dividend sign; everything else follows the sign product
  assign w_neg       = (funct3[2] && funct3[1]) ? w_s1 : (w_s1 ^ w_s2);
  assign w_div0      = (rs2 == '0);
  assign w_ovf       = !funct3[0] && (rs1 == MIN_INT) && (rs2 == '1);

  assign in_ready = (r_state == IDLE) && !flush && !rst;
  assign busy     = (r_state != IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_ONE);

  // Shift-add multiply step
  logic [XLEN-1:0]   w_mul_add;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_prod_next, w_prod_fix;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mul_add   = r_prod[0] ? r_mcand : '0;
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, w_mul_add};
  assign w_prod_next = {w_mul_sum, r_prod[XLEN-1:1]};
  // The whole double-width product is negated before a half is picked
  assign w_prod_fix  = r_neg ? -w_prod_next : w_prod_next;
  assign w_mul_res   = (r_op == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

  // Restoring divide step on an XLEN+1-bit partial remainder. Since the
  // remainder stays below the divisor, the shifted value is below twice the
  // divisor and bit XLEN of the difference is a clean borrow flag.
  logic [XLEN:0]   w_div_part, w_div_diff;
  logic            w_div_ge;
  logic [XLEN-1:0] w_rem_next, w_quo_next, w_div_raw, w_div_res;

  assign w_div_part = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff = w_div_part - {1'b0, r_dvsr};
  assign w_div_ge   = !w_div_diff[XLEN];
  assign w_rem_next = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_part[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_div_ge};
  assign w_div_raw  = r_op[1] ? w_rem_next : w_quo_next;
  assign w_div_res  = r_neg ? -w_div_raw : w_div_raw;

  // Control FSM and datapath registers; flush outranks everything but reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
    end else if (flush) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= funct3[1:0];
            r_neg  <= w_neg;
            out_rd <= rd;
            r_cnt  <= CNT_INIT;
            if (!funct3[2]) begin
              r_state <= MUL;
              r_prod  <= {{XLEN{1'b0}}, w_mag1};
              r_mcand <= w_mag2;
            end else if (w_div0) begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              out_data  <= funct3[1] ? rs1 : '1;
            end else if (w_ovf) begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              out_data  <= funct3[1] ? '0 : MIN_INT;
            end else begin
              r_state <= DIV;
              r_rem   <= '0;
              r_quo   <= w_mag1;
              r_dvsr  <= w_mag2;
            end
          end
        end
        MUL: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            out_data  <= w_mul_res;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            out_data  <= w_div_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
